// File: rtl/relu_maxpool2x2_stream.sv
// rtl/relu_maxpool2x2_stream.sv - streaming ReLU + 2x2 stride-2 max-pool over one raster-order channel
module relu_maxpool2x2_stream #(
  parameter int N = 24,
  parameter int Q = 13,
  parameter int H = 32,
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int LW = (W > 2) ? $clog2(W / 2) : 1;
  // 0.0 in the QN format; the data format passes through unscaled.
  localparam logic [N-1:0] FIX_ZERO = N'(0) << Q;

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [N-1:0]  h;
  logic [N-1:0]  linebuf [W/2];

  logic          accept;
  logic          col_end;
  logic          row_end;
  logic [LW-1:0] lb_idx;
  logic [N-1:0]  pair_max;
  logic [N-1:0]  win_max;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(W - 1));
  assign row_end  = (row == RW'(H - 1));
  assign lb_idx   = LW'(col >> 1);
  assign pair_max = smax(h, in_data);
  assign win_max  = smax(pair_max, linebuf[lb_idx]);

  // Every entry is rewritten on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!global_rst && accept && col[0] && !row[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      col       <= '0;
      row       <= '0;
      h         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) begin
          h <= in_data;
        end else if (row[0]) begin
          // A same-cycle transfer is overridden here, so out_valid stays high on reload.
          out_data  <= win_max[N-1] ? FIX_ZERO : win_max;
          out_last  <= row_end && col_end;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
